// File: rtl/video_scan_generator.sv
`default_nettype none
// ============================================================================
// Module   : video_scan_generator
// Purpose  : Pixel-rate raster timing (hsync/vsync/active) plus a linear
//            framebuffer read address, optionally rotated by 180 degrees.
// Revision : 1.0 - initial release
// ============================================================================
module video_scan_generator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_POL    = 0,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  pixel_en,
    input  logic                  rotate_in,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  active,
    output logic                  fb_rd_en,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  frame_start,
    output logic                  rotate_active
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    // One extra bit of headroom so sync-end compares still fit when a back porch is 0
    localparam int c_HW = $clog2(c_H_TOTAL + 1);
    localparam int c_VW = $clog2(c_V_TOTAL + 1);

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_START   = c_HW'(H_ACTIVE + H_FRONT);
    localparam logic [c_HW-1:0] c_HS_END     = c_HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_START   = c_VW'(V_ACTIVE + V_FRONT);
    localparam logic [c_VW-1:0] c_VS_END     = c_VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic            c_SYNC_ON    = (SYNC_POL != 0);
    localparam logic [ADDR_WIDTH-1:0] c_FB_W    = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [ADDR_WIDTH-1:0] c_FB_LAST =
        ADDR_WIDTH'((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT) - 1);

    logic [c_HW-1:0]       r_h_cnt;
    logic [c_VW-1:0]       r_v_cnt;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_active;
    logic [ADDR_WIDTH-1:0] r_fb_addr;
    logic                  r_frame_start;
    logic                  r_rotate_active;

    logic                  w_h_wrap;
    logic                  w_v_wrap;
    logic                  w_frame_edge;
    logic                  w_active;
    logic                  w_hs_on;
    logic                  w_vs_on;
    logic                  w_rot;
    logic [c_HW-1:0]       w_fx;
    logic [c_VW-1:0]       w_fy;
    logic [ADDR_WIDTH-1:0] w_n;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_h_wrap     = (r_h_cnt == c_H_LAST);
    assign w_v_wrap     = (r_v_cnt == c_V_LAST);
    assign w_frame_edge = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_active     = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hs_on      = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign w_vs_on      = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

    // The frame-start edge must already use the rotation value it is latching
    assign w_rot  = w_frame_edge ? rotate_in : r_rotate_active;
    assign w_fx   = r_h_cnt >> SCALE_SHIFT;
    assign w_fy   = r_v_cnt >> SCALE_SHIFT;
    assign w_n    = ADDR_WIDTH'(w_fy) * c_FB_W + ADDR_WIDTH'(w_fx);
    assign w_addr = w_rot ? (c_FB_LAST - w_n) : w_n;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_h_cnt         <= '0;
            r_v_cnt         <= '0;
            r_hsync         <= ~c_SYNC_ON;
            r_vsync         <= ~c_SYNC_ON;
            r_active        <= 1'b0;
            r_fb_addr       <= '0;
            r_frame_start   <= 1'b0;
            r_rotate_active <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (pixel_en) begin
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
                r_hsync  <= w_hs_on ? c_SYNC_ON : ~c_SYNC_ON;
                r_vsync  <= w_vs_on ? c_SYNC_ON : ~c_SYNC_ON;
                r_active <= w_active;
                if (w_active) begin
                    r_fb_addr <= w_addr;
                end
                if (w_frame_edge) begin
                    r_rotate_active <= rotate_in;
                    r_frame_start   <= 1'b1;
                end
            end
        end
    end

    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign active        = r_active;
    assign fb_rd_en      = r_active;
    assign fb_addr       = r_fb_addr;
    assign frame_start   = r_frame_start;
    assign rotate_active = r_rotate_active;

endmodule
`default_nettype wire
